uart_tx_feeder: RTL

- Memory-to-UART transmit engine; the outbound counterpart of the UART-receive-to-memory path managed by the arbiter.
- On a start command it reads a block of bytes from data memory through an arbiter-granted read port and feeds them one at a time to a uart instance's txData/txEnable, pacing on tx_busy.
- Sits between the arbiter/data-memory read mux and one uart transmitter.

---
 rtl/uart_tx_feeder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: memory-to-UART transmit engine.
//
// On an accepted start command the block reads `length` bytes starting at
// `baseAddr` through an arbiter-granted read port and hands them one at a
// time to a uart transmitter, pacing on the uart's tx_busy.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   start        in   one-cycle start command, sampled only while idle
//   baseAddr     in   first memory address (latched on start)
//   length       in   number of bytes to send (latched on start)
//   busy         out  high whenever the FSM is not idle
//   done         out  one-cycle pulse at the end of a transfer
//   timeoutErr   out  sticky busy-timeout flag, cleared by the next start
//   memRead      out  memory read request
//   memAddress   out  read address (0 whenever memRead is low)
//   memGrant     in   arbiter grant for the current request
//   memReadData  in   read data, valid the cycle after memRead & memGrant
//   txData       out  byte presented to the uart
//   txEnable     out  one-cycle pulse starting a uart transmission
//   txBusy       in   uart tx_busy
//
// Build option
//   UART_TX_MARKER_STOP_EN  when defined, a byte equal to 8'h0c read from
//                           memory ends the transfer without being sent.
module uart_tx_feeder #(
  parameter int ADDR_WIDTH   = 8,
  parameter int LEN_WIDTH    = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] baseAddr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  timeoutErr,
  output logic                  memRead,
  output logic [ADDR_WIDTH-1:0] memAddress,
  input  logic                  memGrant,
  input  logic [7:0]            memReadData,
  output logic [7:0]            txData,
  output logic                  txEnable,
  input  logic                  txBusy
);

  localparam int TW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  // The timer holds the number of WAITBUSY cycles already spent. Leaving
  // WAITBUSY when it equals BUSY_TIMEOUT-2 places FINISH (and the error flag)
  // exactly BUSY_TIMEOUT cycles after the txEnable cycle.
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 2);
  localparam logic [7:0]    END_MARKER = 8'h0c;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RDATA,
    S_WAITIDLE,
    S_SEND,
    S_WAITBUSY,
    S_WAITDONE,
    S_FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [7:0]            txdata_q, txdata_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  terr_q, terr_d;
  logic                  zdone_q, zdone_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      txdata_q <= '0;
      timer_q  <= '0;
      terr_q   <= 1'b0;
      zdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      txdata_q <= txdata_d;
      timer_q  <= timer_d;
      terr_q   <= terr_d;
      zdone_q  <= zdone_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    txdata_d = txdata_q;
    timer_d  = timer_q;
    terr_d   = terr_q;
    zdone_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          terr_d = 1'b0;
          if (length != '0) begin
            addr_d  = baseAddr;
            cnt_d   = length;
            state_d = S_REQ;
          end else begin
            // Empty transfer: acknowledge with done next cycle, stay idle.
            zdone_d = 1'b1;
          end
        end
      end

      S_REQ: begin
        if (memGrant) begin
          state_d = S_RDATA;
        end
      end

      S_RDATA: begin
`ifdef UART_TX_MARKER_STOP_EN
        if (memReadData == END_MARKER) begin
          state_d = S_FINISH;
        end else begin
          txdata_d = memReadData;
          state_d  = S_WAITIDLE;
        end
`else
        txdata_d = memReadData;
        state_d  = S_WAITIDLE;
`endif
      end

      S_WAITIDLE: begin
        if (!txBusy) begin
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        timer_d = '0;
        state_d = S_WAITBUSY;
      end

      S_WAITBUSY: begin
        if (txBusy) begin
          state_d = S_WAITDONE;
        end else if (timer_q == TMO_LAST) begin
          terr_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_WAITDONE: begin
        if (!txBusy) begin
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_REQ;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All outputs are decoded from registered state, so a reset edge clears
  // them together and cannot leave a stray txEnable/memRead/done behind.
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FINISH) || zdone_q;
  assign timeoutErr = terr_q;
  assign memRead    = (state_q == S_REQ);
  assign memAddress = memRead ? addr_q : '0;
  assign txData     = txdata_q;
  assign txEnable   = (state_q == S_SEND);

endmodule
